s4ga_cfg_sequencer: RTL and testbench
=====================================

Name: s4ga_cfg_sequencer

Overview:
Owns the s4ga configuration stream. A host loads one full LUT-config frame (N LUTs x LL segments) into an internal segment RAM. The sequencer then drives the fabric's rst for the required reset window and replays the frame on si, gap-free and cycle-aligned, forever.
It sits between the host/byte-loader and the s4ga si/rst pins.

Parameters:
N, 73, number of LUTs in the target s4ga
K, 5, LUT inputs
SI_W, 4, segment width (si width)
RST_CYC, N+2, cycles fabric reset is held before replay; must be > N
Derived (localparam): N_W=clog2(N); IDX_SEGS=ceil(N_W/SI_W); MASK_SEGS=ceil(2**K/SI_W); LL=K*IDX_SEGS+MASK_SEGS; TOTAL=N*LL; A_W=clog2(TOTAL)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_load  in  1  pulse: enter LOAD
cmd_run  in  1  pulse: start reset+replay
cmd_stop  in  1  pulse: abort LOAD / halt RUN
wr_valid  in  1  host segment valid
wr_ready  out  1  sequencer accepts segment
wr_data  in  SI_W  config segment, frame order
fpga_rst  out  1  to s4ga rst
si_out  out  SI_W  to s4ga si
frame_done  out  1  1-cycle pulse on last segment of each frame
loaded  out  1  full frame resident in RAM
busy  out  1  state != IDLE
err  out  1  1-cycle pulse on illegal command
frame_cnt  out  16  completed frames (optional feature)

Behaviour:
- All outputs are registered. Reset values: fpga_rst=1, si_out=0, wr_ready=0, frame_done=0, loaded=0, busy=0, err=0, frame_cnt=0. State=IDLE.
- States: IDLE, LOAD, RST, RUN. Command priority when several arrive in one cycle: stop > load > run.
- IDLE:
  - fpga_rst=1, si_out=0.
  - cmd_load: go to LOAD, set wr_addr=0, clear loaded.
  - cmd_run with loaded=1: go to RST, clear the reset counter.
  - cmd_run with loaded=0: err pulse, stay in IDLE.
  - cmd_stop: no-op.
- LOAD:
  - wr_ready=1 in every LOAD cycle except the cycle after the last accept.
  - Handshake is wr_valid&wr_ready: mem[wr_addr]<=wr_data, wr_addr++.
  - On accept at wr_addr==TOTAL-1: loaded<=1, wr_ready<=0, go to IDLE next cycle.
  - cmd_stop: go to IDLE, loaded stays 0, partial data discarded.
  - cmd_run or cmd_load in LOAD: err pulse, ignored.
- RST:
  - fpga_rst=1 for exactly RST_CYC cycles, counted from the first RST cycle.
  - The RAM read of segment 0 is issued ahead so that in the first cycle fpga_rst=0, si_out=seg[0]. That cycle is the first RUN cycle.
- RUN:
  - fpga_rst=0. si_out=seg[i], then seg[i+1] on the next cycle.
  - After seg[TOTAL-1] comes seg[0] with no bubble (wrap-around).
  - frame_done=1 in the cycle si_out=seg[TOTAL-1].
  - cmd_stop: next cycle fpga_rst=1, si_out=0, state IDLE, loaded retained.
  - cmd_load or cmd_run in RUN: err pulse, ignored.
- cmd_stop in RST: go to IDLE, fpga_rst stays 1.
- rst mid-operation (any state): immediate return to reset values next cycle, loaded cleared. RAM contents are don't-care.
- Address counters saturate logic by compare-to-TOTAL-1, never by power-of-2 wrap (TOTAL is generally not a power of 2).
- RAM: single write port (LOAD) and single read port (RST/RUN). The two are never active in the same cycle.

Optional Feature:
S4GA_SEQ_FRAME_CNT_EN
- Defined: frame_cnt increments on each frame_done and saturates at 16'hFFFF. It clears on entry to RST.
- Undefined: frame_cnt is tied to 0 and no counter logic is built.

Test Plan:
Use N=5, K=2, SI_W=4, so LL=3, TOTAL=15, RST_CYC=7.
- Reset behaviour: assert rst for 2 cycles -> fpga_rst=1, si_out=0, loaded=0, busy=0, wr_ready=0.
- Load and replay: cmd_load, write segments 0x0..0xE with wr_valid held high -> loaded=1 one cycle after the 15th accept. Then cmd_run -> fpga_rst high for exactly 7 cycles. The next cycle has fpga_rst=0 and si_out=0x0, followed by 0x1..0xE then 0x0 with no gap. frame_done is high in the si_out=0xE cycles.
- Illegal commands: cmd_run with loaded=0 -> err pulse, state IDLE. cmd_load during RUN -> err pulse, si_out sequence undisturbed.
- Abort during LOAD: cmd_load, 6 writes, cmd_stop -> loaded=0, busy=0. A following cmd_run -> err pulse.
- Mid-frame stop and restart: cmd_stop at si_out=0x8 -> next cycle fpga_rst=1, si_out=0. A later cmd_run replays from 0x0 after 7 reset cycles.
- Backpressure, rst and frame counter:
  - wr_valid toggled randomly during LOAD -> exactly the 15 segments stored, in order.
  - rst asserted during RUN -> all outputs return to reset values.
  - With S4GA_SEQ_FRAME_CNT_EN defined: frame_cnt=3 after 3 frame_done pulses, and 0 after re-run.

Source files
------------

// File: rtl/s4ga_cfg_sequencer.sv
// s4ga configuration sequencer: loads one LUT-config frame, then holds
// fabric reset and replays the frame on si forever. Option: S4GA_SEQ_FRAME_CNT_EN.
module s4ga_cfg_sequencer #(
    parameter int N       = 73,
    parameter int K       = 5,
    parameter int SI_W    = 4,
    parameter int RST_CYC = N + 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_load,
    input  logic            cmd_run,
    input  logic            cmd_stop,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [SI_W-1:0] wr_data,
    output logic            fpga_rst,
    output logic [SI_W-1:0] si_out,
    output logic            frame_done,
    output logic            loaded,
    output logic            busy,
    output logic            err,
    output logic [15:0]     frame_cnt
);

    localparam int N_W       = $clog2(N);
    localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
    localparam int MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W;
    localparam int LL        = K * IDX_SEGS + MASK_SEGS;
    localparam int TOTAL     = N * LL;
    localparam int A_W       = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int RC_W      = $clog2(RST_CYC + 1);

    localparam logic [A_W-1:0]  LAST    = A_W'(TOTAL - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RST,
        S_RUN
    } state_t;

    state_t state_q, state_d;

    logic [A_W-1:0]  wr_addr_q, wr_addr_d;
    logic [A_W-1:0]  rd_addr_q, rd_addr_d;
    logic [RC_W-1:0] rcnt_q, rcnt_d;
    logic            loaded_q, loaded_d;
    logic            wr_ready_q, wr_ready_d;
    logic            fpga_rst_q, fpga_rst_d;
    logic            fdone_q, fdone_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [SI_W-1:0] si_q;

    logic            accept;
    logic            wr_last;
    logic            rd_en;

    logic [SI_W-1:0] mem_q [TOTAL];

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rcnt_q     <= '0;
            loaded_q   <= 1'b0;
            wr_ready_q <= 1'b0;
            fpga_rst_q <= 1'b1;
            fdone_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            rcnt_q     <= rcnt_d;
            loaded_q   <= loaded_d;
            wr_ready_q <= wr_ready_d;
            fpga_rst_q <= fpga_rst_d;
            fdone_q    <= fdone_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Next state; stop beats load beats run
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!cmd_stop) begin
                    if (cmd_load)
                        state_d = S_LOAD;
                    else if (cmd_run && loaded_q)
                        state_d = S_RST;
                end
            end
            S_LOAD: begin
                // wr_ready low in LOAD marks the cycle after the final accept
                if (cmd_stop || !wr_ready_q)
                    state_d = S_IDLE;
            end
            S_RST: begin
                if (cmd_stop)
                    state_d = S_IDLE;
                else if (rcnt_q == RC_LAST)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (cmd_stop)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of counters and outputs
    always_comb begin
        accept  = (state_q == S_LOAD) && wr_ready_q && wr_valid;
        wr_last = accept && (wr_addr_q == LAST);
        // The read for the first RUN cycle is issued on the last RST cycle
        rd_en   = (state_d == S_RUN);

        wr_addr_d = wr_addr_q;
        if (state_q == S_IDLE && state_d == S_LOAD)
            wr_addr_d = '0;
        else if (accept)
            wr_addr_d = wr_last ? '0 : wr_addr_q + 1'b1;

        loaded_d = loaded_q;
        if (state_q == S_IDLE && state_d == S_LOAD)
            loaded_d = 1'b0;
        else if (wr_last && !cmd_stop)
            loaded_d = 1'b1;

        wr_ready_d = (state_d == S_LOAD) && !wr_last;
        rcnt_d     = (state_q == S_RST) ? rcnt_q + 1'b1 : '0;

        if (rd_en)
            rd_addr_d = (rd_addr_q == LAST) ? '0 : rd_addr_q + 1'b1;
        else
            rd_addr_d = '0;

        fpga_rst_d = !rd_en;
        fdone_d    = rd_en && (rd_addr_q == LAST);
        busy_d     = (state_d != S_IDLE);

        err_d = 1'b0;
        unique case (state_q)
            S_IDLE:  err_d = cmd_run && !cmd_load && !cmd_stop && !loaded_q;
            default: err_d = (cmd_load || cmd_run) && !cmd_stop;
        endcase
    end

    // Segment RAM write port
    always_ff @(posedge clk) begin
        if (accept)
            mem_q[wr_addr_q] <= wr_data;
    end

    // Segment RAM read port, registered straight into si
    always_ff @(posedge clk) begin
        if (rst)
            si_q <= '0;
        else
            si_q <= rd_en ? mem_q[rd_addr_q] : '0;
    end

`ifdef S4GA_SEQ_FRAME_CNT_EN
    logic [15:0] fcnt_q;

    // Completed-frame counter, cleared when a new replay starts
    always_ff @(posedge clk) begin
        if (rst)
            fcnt_q <= '0;
        else if (state_q != S_RST && state_d == S_RST)
            fcnt_q <= '0;
        else if (fdone_q && fcnt_q != 16'hFFFF)
            fcnt_q <= fcnt_q + 16'd1;
    end

    assign frame_cnt = fcnt_q;
`else
    assign frame_cnt = '0;
`endif

    assign wr_ready   = wr_ready_q;
    assign fpga_rst   = fpga_rst_q;
    assign si_out     = si_q;
    assign frame_done = fdone_q;
    assign loaded     = loaded_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_s4ga_cfg_sequencer.sv
// Directed bench for s4ga_cfg_sequencer with N=5, K=2, SI_W=4
// (LL=3, TOTAL=15, RST_CYC=7).
module tb_s4ga_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_load = 1'b0;
    logic        cmd_run = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_data = 4'h0;
    logic        fpga_rst;
    logic [3:0]  si_out;
    logic        frame_done;
    logic        loaded;
    logic        busy;
    logic        err;
    logic [15:0] frame_cnt;

    int vecs = 0;
    int miss = 0;

    s4ga_cfg_sequencer #(
        .N(5), .K(2), .SI_W(4), .RST_CYC(7)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .fpga_rst(fpga_rst), .si_out(si_out), .frame_done(frame_done),
        .loaded(loaded), .busy(busy), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_fpga_rst"}, 32'(fpga_rst), 1);
        chk({tag, "_si"}, 32'(si_out), 0);
        chk({tag, "_loaded"}, 32'(loaded), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 0);
        chk({tag, "_fdone"}, 32'(frame_done), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 0);
    endtask

    // After cmd_run is sampled: 7 reset cycles, then si=0 with rst low
    task automatic chk_rst_window(input string tag);
        for (int c = 0; c < 7; c++) begin
            chk({tag, "_hold"}, 32'(fpga_rst), 1);
            tick();
        end
        chk({tag, "_release"}, 32'(fpga_rst), 0);
    endtask

    initial begin
        int k;
        int cyc;
        logic [15:0] fc_exp;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk_idle_reset("reset");
        rst = 1'b0;
        tick();

        // Run with nothing loaded
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk("run_unloaded_err", 32'(err), 1);
        chk("run_unloaded_busy", 32'(busy), 0);
        tick();
        chk("err_one_cycle", 32'(err), 0);

        // Load 0x0..0xE with valid held high
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        chk("load_ready", 32'(wr_ready), 1);
        chk("load_busy", 32'(busy), 1);
        wr_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wr_data = 4'(i);
            chk("load_not_yet", 32'(loaded), 0);
            tick();
        end
        wr_valid = 1'b0;
        chk("loaded_set", 32'(loaded), 1);
        chk("ready_drop", 32'(wr_ready), 0);
        tick();
        chk("load_idle", 32'(busy), 0);
        chk("load_kept", 32'(loaded), 1);

        // Replay, with an illegal cmd_load in the middle
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk_rst_window("run1");
        chk("run1_seg0", 32'(si_out), 0);
        for (int j = 1; j <= 45; j++) begin
            cmd_load = (j == 21);
            tick();
            chk("run1_si", 32'(si_out), 32'(j % 15));
            chk("run1_rst", 32'(fpga_rst), 0);
            chk("run1_fdone", 32'(frame_done), 32'(j % 15 == 14));
            chk("run1_err", 32'(err), 32'(j == 21));
        end
        cmd_load = 1'b0;
`ifdef S4GA_SEQ_FRAME_CNT_EN
        fc_exp = 16'd3;
`else
        fc_exp = 16'd0;
`endif
        chk("fcnt_three", 32'(frame_cnt), 32'(fc_exp));

        // Stop at si=8
        cyc = 0;
        while (si_out != 4'h8 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("reach_seg8", 32'(si_out), 8);
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk("stop_rst", 32'(fpga_rst), 1);
        chk("stop_si", 32'(si_out), 0);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_loaded", 32'(loaded), 1);
        tick();

        // Restart replays from segment 0
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk("rerun_fcnt", 32'(frame_cnt), 0);
        chk_rst_window("run2");
        chk("run2_seg0", 32'(si_out), 0);
        tick();
        chk("run2_seg1", 32'(si_out), 1);
        tick();
        chk("run2_seg2", 32'(si_out), 2);

        // rst in RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_reset("rst_run");
        tick();

        // Abort a partial load
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 4'(i + 3);
            tick();
        end
        wr_valid = 1'b0;
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        chk("abort_loaded", 32'(loaded), 0);
        chk("abort_busy", 32'(busy), 0);
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk("abort_run_err", 32'(err), 1);
        chk("abort_run_busy", 32'(busy), 0);
        tick();

        // Load with random backpressure, data 0xF..0x1
        cmd_load = 1'b1;
        tick();
        cmd_load = 1'b0;
        k = 0;
        cyc = 0;
        while (!loaded && cyc < 300) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = 4'(15 - k);
            if (wr_valid && wr_ready)
                k++;
            tick();
            cyc++;
        end
        wr_valid = 1'b0;
        chk("bp_loaded", 32'(loaded), 1);
        chk("bp_count", 32'(k), 15);
        tick();
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        chk_rst_window("run3");
        for (int j = 0; j < 16; j++) begin
            chk("bp_si", 32'(si_out), 32'(15 - (j % 15)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
